serial_adc_reader: RTL and testbench

Master-side reader for the board's 12-bit serial SAR ADC (ADS7883-style 3-wire SPI).
- Drives adc_cs and adc_sclk, and shifts in adc_sd.
- Presents each conversion result as a parallel word on a valid/ready output.
- Sits between the ADC pins and the sample consumer, e.g. the FFT/waterfall front end.

---
 rtl/adc_pkg.sv | 12 +
 rtl/adc_sclk_gen.sv | 37 +++
 rtl/serial_adc_reader.sv | 127 ++++++++++++
 tb/tb_serial_adc_reader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared state type, default sizes and counter sizing helper for the serial ADC reader.
package adc_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} adc_state_t;

    localparam int ADC_WIDTH      = 12;
    localparam int ADC_FRAME_BITS = 16;

    // Bits needed to hold any count from 0 to n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/adc_sclk_gen.sv
// ADC serial clock divider: sclk idles high, toggles every CLK_DIV cycles while enabled,
// and flags the cycle before each rising/falling transition.
module adc_sclk_gen import adc_pkg::*; #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);
    localparam int DW = cnt_width(CLK_DIV);

    logic [DW-1:0] cnt;
    logic          tick;

    // Strobes are independent of en so the FSM can use them to decide en without a loop.
    assign tick = (cnt == DW'(CLK_DIV - 1));
    assign rise = tick && !sclk;
    assign fall = tick && sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (tick) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + DW'(1);
        end
    end
endmodule

// File: rtl/serial_adc_reader.sv
// Master reader for a 3-wire serial SAR ADC with a single-entry valid/ready sample buffer.
// Optional ADC_LEAD_ZERO_CHECK_EN adds a sticky frame_err output for a non-zero leading bit.
module serial_adc_reader import adc_pkg::*; #(
    parameter int WIDTH        = ADC_WIDTH,
    parameter int CLK_DIV      = 2,
    parameter int FRAME_BITS   = ADC_FRAME_BITS,
    parameter int QUIET_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             adc_cs,
    output logic             adc_sclk,
    input  logic             adc_sd,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             busy,
    output logic             overrun
`ifdef ADC_LEAD_ZERO_CHECK_EN
    ,
    output logic             frame_err
`endif
);
    localparam int BW = cnt_width(FRAME_BITS);
    localparam int QW = cnt_width(QUIET_CYCLES);

    logic [1:0]       rst_sync;
    logic             rst_n;
    adc_state_t       state, state_nx;
    logic [BW-1:0]    bit_cnt;
    logic [QW-1:0]    quiet_cnt;
    logic [WIDTH-1:0] shreg;
    logic             sclk_en, sclk_rise, sclk_fall, cs_nx, frame_done;

    // Reset asserts immediately, releases two clocks after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sclk_en),
        .sclk  (adc_sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SETUP;
            SETUP:   if (sclk_fall) state_nx = SHIFT;
            SHIFT:   if (sclk_fall && bit_cnt == BW'(FRAME_BITS)) state_nx = QUIET;
            QUIET:   if (quiet_cnt == QW'(QUIET_CYCLES - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // sclk is disabled on the final edge so the last high phase simply continues into idle.
    always_comb begin
        busy       = (state != IDLE);
        cs_nx      = !(state_nx == SETUP || state_nx == SHIFT);
        sclk_en    = (state == SETUP || state == SHIFT) && !cs_nx;
        frame_done = (state == SHIFT) && (state_nx == QUIET);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_cs    <= 1'b1;
            bit_cnt   <= '0;
            quiet_cnt <= '0;
            shreg     <= '0;
        end else begin
            adc_cs    <= cs_nx;
            quiet_cnt <= (state == QUIET) ? quiet_cnt + QW'(1) : '0;
            if (state != SHIFT)
                bit_cnt <= '0;
            else if (sclk_rise)
                bit_cnt <= bit_cnt + BW'(1);
            // Bit 0 is the ADC's leading zero; bits past WIDTH are trailing padding.
            if (state == SHIFT && sclk_rise && bit_cnt != '0 && bit_cnt <= BW'(WIDTH))
                shreg <= {shreg[WIDTH-2:0], adc_sd};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (frame_done) begin
            if (!sample_valid || sample_ready) begin
                sample       <= shreg;
                sample_valid <= 1'b1;
            end else begin
                overrun      <= 1'b1;
            end
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

`ifdef ADC_LEAD_ZERO_CHECK_EN
    logic lead;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lead      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (state == SHIFT && sclk_rise && bit_cnt == '0)
                lead <= adc_sd;
            if (frame_done && lead)
                frame_err <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_serial_adc_reader.sv
// Bench for serial_adc_reader: ADC pin model, transaction-level output buffer model, directed timing tests.
module tb_serial_adc_reader;
    localparam int WIDTH        = 12;
    localparam int CLK_DIV      = 2;
    localparam int FRAME_BITS   = 16;
    localparam int QUIET_CYCLES = 4;
    localparam int LAT    = 1 + CLK_DIV + 2 * CLK_DIV * FRAME_BITS;
    localparam int CS_LOW = CLK_DIV + 2 * CLK_DIV * FRAME_BITS;
    localparam int PERIOD = LAT + QUIET_CYCLES;

    logic clk = 0, reset_n = 1, start = 0, adc_sd = 0, sample_ready = 0;
    logic adc_cs, adc_sclk, sample_valid, busy, overrun;
    logic [WIDTH-1:0] sample;
`ifdef ADC_LEAD_ZERO_CHECK_EN
    logic frame_err;
`endif
    int checks = 0, failures = 0;

    serial_adc_reader #(
        .WIDTH(WIDTH), .CLK_DIV(CLK_DIV), .FRAME_BITS(FRAME_BITS), .QUIET_CYCLES(QUIET_CYCLES)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .adc_cs       (adc_cs),
        .adc_sclk     (adc_sclk),
        .adc_sd       (adc_sd),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .overrun      (overrun)
`ifdef ADC_LEAD_ZERO_CHECK_EN
        ,
        .frame_err    (frame_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ADC pin model: leading bit, WIDTH data bits MSB first, zero padding; new bit on each sclk fall.
    logic [WIDTH-1:0] adc_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic             lead_q[$];
    logic [WIDTH-1:0] cur_word;
    logic             cur_lead, lead_one = 0;
    int               fall_idx, rises;

    always @(negedge adc_cs) begin
        cur_word = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
        cur_lead = lead_one;
        fall_idx = 0;
        exp_q.push_back(cur_word);
        lead_q.push_back(cur_lead);
    end

    always @(negedge adc_sclk) begin
        if (!adc_cs) begin
            if (fall_idx == 0)          adc_sd = cur_lead;
            else if (fall_idx <= WIDTH) adc_sd = cur_word[WIDTH - fall_idx];
            else                        adc_sd = 1'b0;
            fall_idx++;
        end
    end

    always @(posedge adc_sclk) if (!adc_cs) rises++;

    // Output buffer model, advanced once per clock from the ready value seen at the edge.
    logic             r_at_edge = 0;
    logic             m_valid = 0, m_ovr = 0, m_err = 0, prev_cs = 1, m_xfer, m_lead;
    logic [WIDTH-1:0] m_sample = '0, m_word, last_xfer = '0;
    int               xfers = 0;

    always @(posedge clk) r_at_edge = sample_ready;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_valid = 0; m_ovr = 0; m_err = 0; m_sample = '0; prev_cs = 1;
            exp_q.delete(); lead_q.delete();
        end else begin
            m_xfer = m_valid && r_at_edge;
            if (m_xfer) begin
                xfers++;
                last_xfer = m_sample;
            end
            if (!prev_cs && adc_cs && exp_q.size() > 0) begin
                m_word = exp_q.pop_front();
                m_lead = lead_q.pop_front();
                if (m_lead) m_err = 1;
                if (!m_valid || r_at_edge) begin
                    m_sample = m_word;
                    m_valid  = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_xfer) begin
                m_valid = 0;
            end
            prev_cs = adc_cs;
            chk("m_valid", sample_valid, m_valid);
            chk("m_overrun", overrun, m_ovr);
            if (m_valid) chk("m_sample", sample, m_sample);
`ifdef ADC_LEAD_ZERO_CHECK_EN
            chk("m_frame_err", frame_err, m_err);
`endif
        end
    end

    // One start pulse, then PERIOD clocks; rdy_n>0 raises ready only for the edge numbered rdy_n.
    task automatic frame(input logic [WIDTH-1:0] w, input int rdy_n, input bit rnd,
                         output int lat, output int cs_low, output int idle_at, output int v_after);
        adc_q.push_back(w);
        @(negedge clk);
        start = 1; rises = 0; lat = -1; cs_low = 0; idle_at = -1; v_after = -1;
        for (int n = 1; n <= PERIOD; n++) begin
            @(negedge clk);
            if (n == 1) start = 0;
            if (rnd) sample_ready = 1'($urandom_range(0, 1));
            if (rdy_n > 0 && n == rdy_n - 1) sample_ready = 1;
            if (rdy_n > 0 && n == rdy_n)     sample_ready = 0;
            if (!adc_cs) cs_low++;
            if (sample_valid && lat < 0) lat = n;
            if (!busy && idle_at < 0) idle_at = n;
            if (n == LAT + 1) v_after = int'(sample_valid);
        end
    endtask

    initial begin
        int lat, cs_low, idle_at, v_after, x0, nf, nr, ng;
        int fall_t[4], rise_t[4];
        logic [WIDTH-1:0] got[4];
        logic prev;

        #1 reset_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_cs", adc_cs, 1);
        chk("rst_sclk", adc_sclk, 1);
        chk("rst_sample", sample, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        @(posedge clk); #2 reset_n = 1;
        repeat (4) @(negedge clk);

        // Single frame, ready high
        sample_ready = 1;
        frame(12'hA5C, 0, 0, lat, cs_low, idle_at, v_after);
        chk("t1_latency", lat, LAT);
        chk("t1_cs_low", cs_low, CS_LOW);
        chk("t1_rises", rises, FRAME_BITS);
        chk("t1_sample", sample, 12'hA5C);
        chk("t1_valid_1cyc", v_after, 0);
        chk("t1_idle_at", idle_at, PERIOD);

        // start held high for three frames
        adc_q.push_back(12'h000); adc_q.push_back(12'h001); adc_q.push_back(12'h002);
        for (int i = 0; i < 4; i++) begin fall_t[i] = 0; rise_t[i] = 0; got[i] = '0; end
        nf = 0; nr = 0; ng = 0; prev = 1;
        @(negedge clk); start = 1; rises = 0;
        for (int n = 1; n <= 3 * PERIOD + 4; n++) begin
            @(negedge clk);
            if (n == 2 * PERIOD + 1) start = 0;
            if (prev && !adc_cs && nf < 4) begin fall_t[nf] = n; nf++; end
            if (!prev && adc_cs && nr < 4) begin rise_t[nr] = n; nr++; end
            if (sample_valid && ng < 4) begin got[ng] = sample; ng++; end
            prev = adc_cs;
        end
        chk("t2_frames", nf, 3);
        chk("t2_period_a", fall_t[1] - fall_t[0], PERIOD);
        chk("t2_period_b", fall_t[2] - fall_t[1], PERIOD);
        chk("t2_cs_high", fall_t[1] - rise_t[0], QUIET_CYCLES + 1);
        chk("t2_rises", rises, 3 * FRAME_BITS);
        chk("t2_nsamples", ng, 3);
        for (int i = 0; i < 3; i++) chk("t2_sample", got[i], i);

        // Frame end in the same cycle the old sample is accepted
        sample_ready = 0;
        frame(12'h111, 0, 0, lat, cs_low, idle_at, v_after);
        x0 = xfers;
        frame(12'h222, LAT, 0, lat, cs_low, idle_at, v_after);
        #1;
        chk("t4_sample", sample, 12'h222);
        chk("t4_valid", sample_valid, 1);
        chk("t4_overrun", overrun, 0);
        chk("t4_xfers", xfers - x0, 1);
        chk("t4_xfer_val", last_xfer, 12'h111);

        // Overrun: two frames with ready low
        @(negedge clk); sample_ready = 1;
        @(negedge clk); sample_ready = 0;
        frame(12'h123, 0, 0, lat, cs_low, idle_at, v_after);
        frame(12'h456, 0, 0, lat, cs_low, idle_at, v_after);
        chk("t3_sample", sample, 12'h123);
        chk("t3_overrun", overrun, 1);
        #1 x0 = xfers;
        @(negedge clk); sample_ready = 1;
        @(negedge clk); sample_ready = 0;
        #1;
        chk("t3_xfers", xfers - x0, 1);
        chk("t3_xfer_val", last_xfer, 12'h123);
        chk("t3_valid", sample_valid, 0);
        chk("t3_overrun_sticky", overrun, 1);

        // Reset in the middle of a frame while a sample is pending
        frame(12'h0F0, 0, 0, lat, cs_low, idle_at, v_after);
        adc_q.push_back(12'h3C3);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        repeat (29) @(negedge clk);
        chk("t5_cs_before", adc_cs, 0);
        #2 reset_n = 0;
        #1;
        chk("t5_cs", adc_cs, 1);
        chk("t5_sclk", adc_sclk, 1);
        chk("t5_valid", sample_valid, 0);
        chk("t5_overrun", overrun, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #2 reset_n = 1;
        repeat (4) @(negedge clk);
        sample_ready = 1;
        frame(12'h5A5, 0, 0, lat, cs_low, idle_at, v_after);
        chk("t5_latency", lat, LAT);
        chk("t5_sample", sample, 12'h5A5);

        // Randomized data and ready pattern, checked by the buffer model
        for (int f = 0; f < 8; f++) begin
            frame(WIDTH'($urandom), 0, 1, lat, cs_low, idle_at, v_after);
            repeat ($urandom_range(0, 5)) begin
                @(negedge clk);
                sample_ready = 1'($urandom_range(0, 1));
            end
        end

        // Leading bit stuck high
        @(negedge clk); sample_ready = 1;
        @(negedge clk);
        lead_one = 1;
        frame(12'hFFF, 0, 0, lat, cs_low, idle_at, v_after);
        lead_one = 0;
        chk("t6_sample", sample, 12'hFFF);
`ifdef ADC_LEAD_ZERO_CHECK_EN
        chk("t6_frame_err", frame_err, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
